// File: rtl/rf_mp_clr_if.sv
// Bus bundle for the multi-port register file: write ports, read ports,
// soft-clear request and status.
interface rf_mp_clr_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int NWR   = 2,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
);
  // Handshake: no backpressure. A write with we[i]=1 is taken at the posedge
  // only while busy=0 and clear=0; otherwise it is silently dropped.
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*WIDTH-1:0] din;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] q;
  logic                 clear;
  logic                 busy;
  logic                 dbg_state;

  modport master (
    output we, waddr, din, raddr, clear,
    input  q, busy, dbg_state
  );
  modport slave (
    input  we, waddr, din, raddr, clear,
    output q, busy, dbg_state
  );
endinterface

// File: rtl/rf_mp_clr.sv
// Multi-port register file with highest-port-wins writes, optional write-to-read
// bypass, selectable sync/comb reads and a clear sequencer after reset/clear.
module rf_mp_clr #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 8,
  parameter int NWR     = 2,
  parameter int NRD     = 2,
  parameter int SYNC_RD = 1,
  parameter int BYPASS  = 1,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset,
  rf_mp_clr_if.slave bus
);
  typedef enum logic {ST_READY = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic             busy_q;
  logic [WIDTH-1:0] rf [DEPTH];

  logic [NWR-1:0]   wr_ok;
  logic [AW-1:0]    wa [NWR];
  logic [WIDTH-1:0] wd [NWR];
  logic [AW-1:0]    ra [NRD];
  logic [WIDTH-1:0] rd_arr [NRD];
  logic [WIDTH-1:0] rd_fwd [NRD];

  assign bus.busy      = busy_q;
  assign bus.dbg_state = (state == ST_CLEAR);

  always_comb begin
    for (int i = 0; i < NWR; i++) begin
      wa[i]    = bus.waddr[i*AW +: AW];
      wd[i]    = bus.din[i*WIDTH +: WIDTH];
      wr_ok[i] = bus.we[i] && (int'(wa[i]) < DEPTH) && (state == ST_READY) && !bus.clear;
    end
  end

  // Later ports override earlier ones, giving highest-index priority on both
  // the array write and the forwarded read value.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      ra[j]     = bus.raddr[j*AW +: AW];
      rd_arr[j] = '0;
      if (int'(ra[j]) < DEPTH) rd_arr[j] = rf[ra[j]];
      rd_fwd[j] = rd_arr[j];
      if (BYPASS != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_ok[i] && (wa[i] == ra[j])) rd_fwd[j] = wd[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (ptr == AW'(DEPTH - 1)) begin
        state  <= ST_READY;
        ptr    <= '0;
        busy_q <= 1'b0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end else if (bus.clear) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      busy_q <= 1'b1;
    end
  end

  // The array has no reset; the sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      rf[ptr] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i]) rf[wa[i]] <= wd[i];
      end
    end
  end

  generate
    if (SYNC_RD != 0) begin : g_sync
      logic [NRD*WIDTH-1:0] q_r;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_r <= '0;
        end else begin
          for (int j = 0; j < NRD; j++) begin
            q_r[j*WIDTH +: WIDTH] <= (state == ST_CLEAR) ? '0 : rd_fwd[j];
          end
        end
      end
      assign bus.q = q_r;
    end else begin : g_comb
      always_comb begin
        bus.q = '0;
        for (int j = 0; j < NRD; j++) begin
          bus.q[j*WIDTH +: WIDTH] = busy_q ? '0 : rd_arr[j];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_rf_mp_clr.sv
// Directed bench for rf_mp_clr: four instances cover the default build,
// BYPASS=0, DEPTH=6 and SYNC_RD=0.
module tb_rf_mp_clr;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_mp_clr_if                if_a ();
  rf_mp_clr_if                if_b ();
  rf_mp_clr_if #(.DEPTH(6))   if_c ();
  rf_mp_clr_if                if_d ();

  rf_mp_clr                   dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  rf_mp_clr #(.BYPASS(0))     dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
  rf_mp_clr #(.DEPTH(6))      dut_c (.clk(clk), .reset(rst_c), .bus(if_c));
  rf_mp_clr #(.SYNC_RD(0))    dut_d (.clk(clk), .reset(rst_d), .bus(if_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_a.we = '0; if_a.waddr = '0; if_a.din = '0; if_a.raddr = '0; if_a.clear = 1'b0;
    if_b.we = '0; if_b.waddr = '0; if_b.din = '0; if_b.raddr = '0; if_b.clear = 1'b0;
    if_c.we = '0; if_c.waddr = '0; if_c.din = '0; if_c.raddr = '0; if_c.clear = 1'b0;
    if_d.we = '0; if_d.waddr = '0; if_d.din = '0; if_d.raddr = '0; if_d.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    tick(); tick();
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", if_a.busy); end
    n_cmp++; if (if_a.q !== 12'h000) begin n_err++; $display("FAIL reset_q: got %h expected 000", if_a.q); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL release_busy: got %b expected 1", if_a.busy); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (if_a.busy !== (k < 8)) begin n_err++; $display("FAIL busy_seq k=%0d: got %b expected %b", k, if_a.busy, (k < 8)); end
      n_cmp++; if (if_a.q !== 12'h000) begin n_err++; $display("FAIL clear_q k=%0d: got %h expected 000", k, if_a.q); end
    end
    n_cmp++; if (if_c.busy !== 1'b0) begin n_err++; $display("FAIL depth6_ready: got %b expected 0", if_c.busy); end
    n_cmp++; if (if_d.busy !== 1'b0) begin n_err++; $display("FAIL comb_ready: got %b expected 0", if_d.busy); end
    for (int a = 0; a < 8; a++) begin
      if_a.raddr = {3'(7 - a), 3'(a)};
      tick();
      n_cmp++; if (if_a.q !== 12'h000) begin n_err++; $display("FAIL post_reset_read a=%0d: got %h expected 000", a, if_a.q); end
    end
  endtask

  task automatic test_dual_write();
    if_a.we = 2'b11; if_a.waddr = {3'd5, 3'd3}; if_a.din = {6'h2A, 6'h15};
    tick();
    if_a.we = 2'b00; if_a.raddr = {3'd5, 3'd3};
    tick();
    n_cmp++; if (if_a.q !== {6'h2A, 6'h15}) begin n_err++; $display("FAIL dual_write: got %h expected %h", if_a.q, {6'h2A, 6'h15}); end
  endtask

  task automatic test_collision();
    if_a.we = 2'b11; if_a.waddr = {3'd2, 3'd2}; if_a.din = {6'h22, 6'h11};
    tick();
    if_a.we = 2'b00; if_a.raddr = {3'd3, 3'd2};
    tick();
    n_cmp++; if (if_a.q !== {6'h15, 6'h22}) begin n_err++; $display("FAIL collision: got %h expected %h", if_a.q, {6'h15, 6'h22}); end
  endtask

  task automatic test_bypass();
    if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd4}; if_a.din = {6'h00, 6'h3F}; if_a.raddr = {3'd7, 3'd4};
    tick();
    n_cmp++; if (if_a.q !== {6'h00, 6'h3F}) begin n_err++; $display("FAIL bypass: got %h expected %h", if_a.q, {6'h00, 6'h3F}); end
    if_a.we = 2'b11; if_a.waddr = {3'd6, 3'd6}; if_a.din = {6'h02, 6'h01}; if_a.raddr = {3'd6, 3'd4};
    tick();
    n_cmp++; if (if_a.q !== {6'h02, 6'h3F}) begin n_err++; $display("FAIL bypass_collision: got %h expected %h", if_a.q, {6'h02, 6'h3F}); end
    if_a.we = 2'b00;
    if_b.we = 2'b01; if_b.waddr = {3'd0, 3'd4}; if_b.din = {6'h00, 6'h3F}; if_b.raddr = {3'd4, 3'd4};
    tick();
    n_cmp++; if (if_b.q !== 12'h000) begin n_err++; $display("FAIL no_bypass_old: got %h expected 000", if_b.q); end
    if_b.we = 2'b00;
    tick();
    n_cmp++; if (if_b.q !== {6'h3F, 6'h3F}) begin n_err++; $display("FAIL no_bypass_new: got %h expected %h", if_b.q, {6'h3F, 6'h3F}); end
  endtask

  task automatic test_comb_read();
    if_d.we = 2'b01; if_d.waddr = {3'd0, 3'd3}; if_d.din = {6'h00, 6'h15}; if_d.raddr = {3'd3, 3'd3};
    #1;
    n_cmp++; if (if_d.q !== 12'h000) begin n_err++; $display("FAIL comb_old: got %h expected 000", if_d.q); end
    tick();
    if_d.we = 2'b00;
    n_cmp++; if (if_d.q !== {6'h15, 6'h15}) begin n_err++; $display("FAIL comb_new: got %h expected %h", if_d.q, {6'h15, 6'h15}); end
    if_d.clear = 1'b1;
    tick();
    if_d.clear = 1'b0;
    n_cmp++; if (if_d.q !== 12'h000) begin n_err++; $display("FAIL comb_busy_q: got %h expected 000", if_d.q); end
    for (int k = 1; k <= 8; k++) tick();
    n_cmp++; if (if_d.busy !== 1'b0) begin n_err++; $display("FAIL comb_clear_done: got %b expected 0", if_d.busy); end
    n_cmp++; if (if_d.q !== 12'h000) begin n_err++; $display("FAIL comb_cleared: got %h expected 000", if_d.q); end
  endtask

  task automatic test_soft_clear();
    for (int k = 0; k < 4; k++) begin
      if_a.we = 2'b11;
      if_a.waddr = {3'(2*k + 1), 3'(2*k)};
      if_a.din = {6'((2*k + 1)*7 + 3), 6'((2*k)*7 + 3)};
      tick();
    end
    if_a.we = 2'b00; if_a.raddr = {3'd7, 3'd0};
    tick();
    n_cmp++; if (if_a.q !== {6'h34, 6'h03}) begin n_err++; $display("FAIL fill_read: got %h expected %h", if_a.q, {6'h34, 6'h03}); end
    if_a.clear = 1'b1; if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd1}; if_a.din = {6'h00, 6'h07};
    tick();
    if_a.clear = 1'b0; if_a.we = 2'b00;
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL clear_start: got %b expected 1", if_a.busy); end
    n_cmp++; if (if_a.dbg_state !== 1'b1) begin n_err++; $display("FAIL clear_state: got %b expected 1", if_a.dbg_state); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (if_a.busy !== (k < 8)) begin n_err++; $display("FAIL soft_busy k=%0d: got %b expected %b", k, if_a.busy, (k < 8)); end
    end
    for (int a = 0; a < 8; a++) begin
      if_a.raddr = {3'(7 - a), 3'(a)};
      tick();
      n_cmp++; if (if_a.q !== 12'h000) begin n_err++; $display("FAIL soft_cleared a=%0d: got %h expected 000", a, if_a.q); end
    end
  endtask

  task automatic test_clear_held();
    if_a.clear = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) tick();
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL held_ready: got %b expected 0", if_a.busy); end
    tick();
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL held_retrigger: got %b expected 1", if_a.busy); end
    if_a.clear = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL held_release: got %b expected 0", if_a.busy); end
  endtask

  task automatic test_boundary();
    if_c.we = 2'b11; if_c.waddr = {3'd5, 3'd7}; if_c.din = {6'h2A, 6'h3F};
    tick();
    if_c.we = 2'b00; if_c.raddr = {3'd5, 3'd7};
    tick();
    n_cmp++; if (if_c.q !== {6'h2A, 6'h00}) begin n_err++; $display("FAIL oob_drop: got %h expected %h", if_c.q, {6'h2A, 6'h00}); end
    #2 rst_c = 1'b1;
    #1;
    n_cmp++; if (if_c.q !== 12'h000) begin n_err++; $display("FAIL async_q: got %h expected 000", if_c.q); end
    n_cmp++; if (if_c.busy !== 1'b1) begin n_err++; $display("FAIL async_busy: got %b expected 1", if_c.busy); end
    tick();
    rst_c = 1'b0;
    tick(); tick(); tick();
    rst_c = 1'b1;
    n_cmp++; if (if_c.busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy: got %b expected 1", if_c.busy); end
    tick();
    rst_c = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++; if (if_c.busy !== (k < 6)) begin n_err++; $display("FAIL restart_busy k=%0d: got %b expected %b", k, if_c.busy, (k < 6)); end
    end
    tick();
    n_cmp++; if (if_c.q !== 12'h000) begin n_err++; $display("FAIL recleared: got %h expected 000", if_c.q); end
  endtask

  initial begin
    idle();
    test_reset();
    test_dual_write();
    test_collision();
    test_bypass();
    test_comb_read();
    test_soft_clear();
    test_clear_held();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_mp_clr.md
# rf_mp_clr

Parametrised multi-port register file, the next generation of the single-read/single-write RF test block. It provides NWR write ports and NRD read ports over a DEPTH x WIDTH array. Reads are selectable synchronous or combinational, with optional write-to-read bypass. A built-in clear sequencer zeroes the array after reset or on request. It sits in the yosys/LiveHD regression set as the reference multi-port memory inference and bypass case.

## Interface
Parameters:
- WIDTH, 6: data bits per entry.
- DEPTH, 8: number of entries, ≥2, need not be a power of two.
- AW, $clog2(DEPTH): address bits (derived, do not override).
- NWR, 2: write ports, ≥1.
- NRD, 2: read ports, ≥1.
- SYNC_RD, 1: 1 gives registered read data; 0 gives combinational read data.
- BYPASS, 1: with SYNC_RD=1, a same-cycle write to the read address is forwarded to q.

Ports:
- clk, input, 1: the single clock; all state updates on the posedge.
- reset, input, 1: asynchronous, active-high.
- we, input, NWR: per-port write enable.
- waddr, input, NWR*AW: port i address at [i*AW +: AW].
- din, input, NWR*WIDTH: port i data at [i*WIDTH +: WIDTH].
- raddr, input, NRD*AW: port j address at [j*AW +: AW].
- q, output, NRD*WIDTH: port j read data at [j*WIDTH +: WIDTH].
- clear, input, 1: soft clear request, one-cycle pulse or level.
- busy, output, 1: high while the clear sequencer owns the array.

## Operation
- State machine has two states: CLEAR and READY. A clear pointer ptr (AW bits) is used in CLEAR.
- Reset asserted (async): state=CLEAR, ptr=0, q registers=0 (SYNC_RD=1), busy=1. The array itself has no async reset.
- CLEAR:
  - Each clk writes 0 to rf[ptr] and increments ptr.
  - When ptr==DEPTH-1, the write happens and state moves to READY with ptr=0.
  - User writes are ignored. q is forced to 0. The clear input is ignored.
- READY:
  - For each i with we[i]=1 and waddr_i<DEPTH, rf[waddr_i] <= din_i at the posedge.
  - If several ports write the same address in one cycle, the highest port index wins.
  - Writes to waddr≥DEPTH are dropped.
  - clear=1 sampled in READY: go to CLEAR next cycle, ptr=0. All writes in that same cycle are dropped (clear has priority).
- Reads:
  - raddr≥DEPTH returns 0.
  - SYNC_RD=1: q_j <= rf[raddr_j] at the posedge.
  - SYNC_RD=1, BYPASS=1: if a write in the same cycle targets raddr_j, q_j takes the winning din instead of the old contents.
  - SYNC_RD=1, BYPASS=0: a same-cycle write returns the old contents.
  - SYNC_RD=0: q_j = rf[raddr_j] combinationally (0 when busy). A write is visible the cycle after its posedge. BYPASS has no effect.
- busy = (state==CLEAR). It is registered and glitch-free.

## Timing
- Reset release: busy stays high for exactly DEPTH posedges. The first user write is accepted on posedge DEPTH+1 after reset falls.
- Read latency: 1 cycle when SYNC_RD=1, 0 when SYNC_RD=0.
- Write-to-read, no bypass: data is readable on q at cycle N+1 (SYNC_RD=0) or captured at posedge N+1 (SYNC_RD=1).
- Soft clear: clear high at posedge N gives busy=1 from N+1 through N+DEPTH, and READY at N+DEPTH+1.
- Reset asserted mid-clear or mid-operation: the sequencer restarts immediately at ptr=0. Partially cleared entries are simply re-cleared.
- Clear held high continuously: it re-triggers a new CLEAR each time the FSM returns to READY.
- busy is 0 on the cycle the last clear write occurs? No: busy is 1 on the cycle of the last clear write (ptr==DEPTH-1) and 0 on the following cycle.

## Test plan
- Reset sequence: pulse reset with defaults. busy is 1 for 8 cycles then 0. All q=0 throughout. Reading addresses 0..7 afterward returns 0.
- Dual write and read: write port0 addr3=0x15 and port1 addr5=0x2A in one cycle. Next cycle raddr0=3, raddr1=5 gives q0=0x15, q1=0x2A one cycle later.
- Write collision: port0 and port1 both write addr2, with 0x11 and 0x22. A later read of 2 returns 0x22.
- Bypass: write addr4=0x3F while raddr0=4 in the same cycle. With BYPASS=1, q0=0x3F after the edge. With BYPASS=0, q0 shows the old value (0 after clear).
- Soft clear: fill all 8 entries with nonzero data, pulse clear, and also assert we addr1=0x07 in that cycle. busy is 1 for 8 cycles. Afterward all entries read 0, including addr1.
- Boundary and async reset: DEPTH=6. A write to addr7 is dropped and a read of addr7 returns 0. Assert reset at ptr=3 during a clear: busy stays high and 6 further cycles are needed after release.
